// File: rtl/loadreg_arbiter.sv
// rtl/loadreg_arbiter.sv - four-way arbiter and load sequencer for a shared loadreg
// Define LOADREG_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority (0 highest).
module loadreg_arbiter #(
  parameter int WIDTH       = 5,
  parameter int HOLD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] din,
  output logic               load,
  output logic [WIDTH-1:0]   D,
  output logic [3:0]         ack,
  output logic [1:0]         owner,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, GRANT, COOL} state_t;

  localparam logic [7:0] HOLD = 8'(HOLD_CYCLES);

  state_t           state, state_n;
  logic [7:0]       cnt, cnt_n;
  logic             load_n;
  logic [3:0]       ack_n;
  logic [WIDTH-1:0] d_n;
  logic [1:0]       owner_n;
  logic             busy_n;
  logic [1:0]       base;
  logic [1:0]       win;
  logic [WIDTH-1:0] win_data;

`ifdef LOADREG_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr, ptr_n;
  assign base = ptr;
`else
  assign base = 2'd0;
`endif

  // Scan from the farthest offset down so the closest asserted request wins.
  always_comb begin
    win = base;
    for (int k = 3; k >= 0; k--) begin
      if (req[base + 2'(k)]) win = base + 2'(k);
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (win == 2'(i)) win_data = din[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load_n  = 1'b0;
    ack_n   = 4'b0000;
    d_n     = D;
    owner_n = owner;
    busy_n  = busy;
`ifdef LOADREG_ARB_ROUND_ROBIN_EN
    ptr_n   = ptr;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = GRANT;
          load_n  = 1'b1;
          ack_n   = 4'b0001 << win;
          d_n     = win_data;
          owner_n = win;
          busy_n  = 1'b1;
        end
      end
      GRANT: begin
`ifdef LOADREG_ARB_ROUND_ROBIN_EN
        ptr_n = owner + 2'd1;
`endif
        if (HOLD_CYCLES == 0) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          cnt_n   = HOLD;
          state_n = COOL;
        end
      end
      COOL: begin
        if (cnt <= 8'd1) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      load  <= 1'b0;
      ack   <= 4'b0000;
      D     <= '0;
      owner <= 2'd0;
      busy  <= 1'b0;
`ifdef LOADREG_ARB_ROUND_ROBIN_EN
      ptr   <= 2'd0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      load  <= load_n;
      ack   <= ack_n;
      D     <= d_n;
      owner <= owner_n;
      busy  <= busy_n;
`ifdef LOADREG_ARB_ROUND_ROBIN_EN
      ptr   <= ptr_n;
`endif
    end
  end

endmodule

// File: doc/loadreg_arbiter.md
# loadreg_arbiter

Round-robin arbiter and load sequencer that shares one 5-bit load register (`loadreg`) among four requesters. It latches the winning requester's data, drives a single-cycle `load` strobe and data word into the register, returns a one-hot acknowledge, and then enforces a programmable cool-down before the next grant. It sits between the requester logic, such as switch/button capture or counter units, and the shared `loadreg` instance that feeds the display/datapath.

## Interface
- `WIDTH`, default 5: data width; matches the `loadreg` D/Q width.
- `HOLD_CYCLES`, default 2: idle cycles forced after each load, range 0..255.
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req` input 4: per-requester request level; held high until the matching `ack` is seen.
- `din` input 4*WIDTH: requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- `load` output 1: connects to `loadreg.load`; one-cycle strobe.
- `D` output WIDTH: connects to `loadreg.D`; the captured winner data.
- `ack` output 4: one-hot; high for exactly the `load` cycle.
- `owner` output 2: index of the last granted requester.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- All outputs are registered. Reset values: `load`=0, `ack`=0, `D`=0, `owner`=0, `busy`=0. The state resets to IDLE, the hold counter to 0, and the round-robin pointer to 0, so requester 0 has highest priority first.
- States:
  - **IDLE**: if `req`≠0, select the winner, capture `din` slice into `D`, set `owner`, and go to GRANT. If `req`=0, stay in IDLE.
  - **GRANT**: `load`=1 and `ack[owner]`=1 for this cycle only.
    - Advance the pointer to owner+1 mod 4.
    - If `HOLD_CYCLES`=0, go to IDLE; otherwise load the counter with `HOLD_CYCLES` and go to COOL.
  - **COOL**: decrement the counter each cycle and go to IDLE when the counter reaches 1. `req` is ignored during COOL.
- Winner selection: first asserted `req` bit, scanning upward from the pointer with wrap from 3 to 0.
- `D` holds its captured value until the next grant; it is never modified in COOL or IDLE.
- Requests that arrive during GRANT or COOL are not lost. They are evaluated in the first IDLE cycle.
- A `req` bit dropped before it is granted is simply not considered. No partial grant is issued.
- Simultaneous requests are resolved by the pointer only. There is exactly one grant per IDLE→GRANT transition.
- `reset` asserted in any state forces the reset values on the next edge. No `load` is issued on that edge, and any pending grant is abandoned.

## Timing
- Grant latency: `req` is sampled high in IDLE at edge t; `load`, `ack`, `D` and `owner` are valid from t until t+1.
- `loadreg.Q` updates at edge t+1, which makes the request-to-Q latency 2 edges.
- Load period per requester is 2+`HOLD_CYCLES` cycles minimum.
  - `HOLD_CYCLES`=0 gives back-to-back grants every 2 cycles (IDLE, GRANT).
  - The default of 2 gives one grant every 4 cycles.
- `busy` rises in the GRANT cycle and falls in the first IDLE cycle.
- Requester contract: drop `req` on the edge ending the `ack` cycle. A `req` still high in the next IDLE cycle is treated as a new request.

## Configuration
- Macro: `LOADREG_ARB_ROUND_ROBIN_EN`.
- Defined: selection is round-robin as described above.
- Undefined: fixed priority, with requester 0 highest and 3 lowest. The pointer register is not built, and `owner` still reports the winner.
- The remaining timing and the FSM are identical in both builds.

## Test plan
- **Reset:** hold `reset` for 3 cycles with `req`=4'b1111.
  - Expected: all outputs 0 and no `load` throughout.
  - Expected: the first grant after release is requester 0.
- **Single request:** `req`=4'b0100 with slice 2 = 5'h15.
  - Expected: `load`=1, `ack`=4'b0100, `D`=5'h15 one cycle after sampling.
  - Expected: `loadreg.Q`=5'h15 on the following edge.
- **Contention:** all four requesters held at 4'b1111, each re-requesting immediately, default `HOLD_CYCLES`.
  - Round-robin build: grants in order 0,1,2,3,0, spaced 4 cycles apart.
  - Fixed-priority build: grants 0,0,0.
- **Cool-down:** `HOLD_CYCLES`=0 versus 3, with requester 1 continuously re-requesting.
  - Expected: `load` pulses every 2 cycles with `HOLD_CYCLES`=0, and every 5 cycles with 3.
- **Reset mid-operation:** assert `reset` in the GRANT cycle, and separately in the COOL cycle.
  - Expected: on the next edge the state is IDLE, outputs are 0 and `D`=0.
  - Expected: no extra `load` is issued.
- **Request withdrawal:** raise `req[3]` during COOL, then drop it before IDLE.
  - Expected: no grant to requester 3.
  - Expected: `D` keeps the previous value.
